// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the fourbee control unit: sequencer states,
// instruction class and branch condition codes, the HALT immediate and
// the bit positions of each field inside a 12-bit instruction word.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_N      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    localparam logic [3:0] IMM_HALT = 4'b0000;

    localparam int CLS_HI = 11;
    localparam int CLS_LO = 10;
    localparam int IMM_HI = 9;
    localparam int IMM_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 2;

    // Branch resolution against the architectural z/n flags.
    function automatic logic condTaken(input logic [1:0] cond,
                                       input logic z,
                                       input logic n);
        case (cond)
            COND_ALWAYS: return 1'b1;
            COND_Z:      return z;
            COND_N:      return n;
            COND_NZ:     return !z;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile4x4.sv
// regfile4x4
// Four 4-bit general registers with two combinational read ports for
// the ALU operands, a combinational debug read port and one synchronous
// write port. Synchronous active-high reset clears every register; it
// takes priority over a write in the same cycle.
// Ports:
//   clk, rst               clock and synchronous reset
//   i_raddrA / o_rdataA    operand x read port
//   i_raddrB / o_rdataB    operand y read port
//   i_dbgSel / o_dbgData   debug read port
//   i_we, i_waddr, i_wdata write port
module regfile4x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_raddrA,
    output logic [3:0] o_rdataA,
    input  logic [1:0] i_raddrB,
    output logic [3:0] o_rdataB,
    input  logic [1:0] i_dbgSel,
    output logic [3:0] o_dbgData,
    input  logic       i_we,
    input  logic [1:0] i_waddr,
    input  logic [3:0] i_wdata
);

    logic [3:0] r_regs [4];

    // Register storage: reset wins, so a write that lands in a reset
    // cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 4'd0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdataA  = r_regs[i_raddrA];
    assign o_rdataB  = r_regs[i_raddrB];
    assign o_dbgData = r_regs[i_dbgSel];

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl
// Multi-cycle control unit of the fourbee CPU. Fetches 12-bit
// instructions from a synchronous ROM, sequences the external registered
// ALU, keeps pc, ir, z/n flags and (via regfile4x4) the four registers.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   run             execute enable, sampled at instruction boundaries
//   imem_*          program ROM address / enable / data (data one cycle late)
//   alu_op/rx/ry    ALU opcode and operands, non-zero only in EXEC
//   alu_out/z/n     registered ALU result and flags
//   halted, retire  status: HALT reached, instruction-complete pulse
//   pc              program counter
//   dbg_sel/data    combinational register readback
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [11:0]     imem_data,
    output logic [3:0]      alu_op,
    output logic [3:0]      alu_rx,
    output logic [3:0]      alu_ry,
    input  logic [3:0]      alu_out,
    input  logic            alu_z,
    input  logic            alu_n,
    output logic            halted,
    output logic            retire,
    output logic [PC_W-1:0] pc,
    input  logic [1:0]      dbg_sel,
    output logic [3:0]      dbg_data
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [11:0]     r_ir;
    logic            r_z;
    logic            r_n;
    logic            r_imemEn;
    logic [3:0]      r_aluOp;
    logic [3:0]      r_aluRx;
    logic [3:0]      r_aluRy;
    logic            r_halted;
    logic            r_retire;

    logic [1:0]      w_irCls;
    logic [3:0]      w_irImm;
    logic [1:0]      w_irRd;
    logic [1:0]      w_dataCls;
    logic [3:0]      w_dataImm;
    logic [3:0]      w_rdataA;
    logic [3:0]      w_rdataB;
    logic            w_we;
    logic [3:0]      w_wdata;
    logic [PC_W-1:0] w_pcNext;
    logic            w_unused;

    assign w_irCls   = r_ir[CLS_HI:CLS_LO];
    assign w_irImm   = r_ir[IMM_HI:IMM_LO];
    assign w_irRd    = r_ir[RD_HI:RD_LO];
    assign w_dataCls = imem_data[CLS_HI:CLS_LO];
    assign w_dataImm = imem_data[IMM_HI:IMM_LO];
    assign w_unused  = ^r_ir[RS_HI:0];

    // Operands are read in DECODE straight from the ROM word so they can
    // be registered onto the ALU inputs for EXEC. Writes come from LDI in
    // EXEC (immediate) or from WB (ALU result).
    assign w_we    = ((r_state == ST_EXEC) && (w_irCls == CLS_LDI)) || (r_state == ST_WB);
    assign w_wdata = (r_state == ST_WB) ? alu_out : w_irImm;

    regfile4x4 u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_raddrA  (imem_data[RD_HI:RD_LO]),
        .o_rdataA  (w_rdataA),
        .i_raddrB  (imem_data[RS_HI:RS_LO]),
        .o_rdataB  (w_rdataB),
        .i_dbgSel  (dbg_sel),
        .o_dbgData (dbg_data),
        .i_we      (w_we),
        .i_waddr   (w_irRd),
        .i_wdata   (w_wdata)
    );

    // Next pc on completion: a taken branch loads the zero-extended
    // immediate, everything else steps by one and wraps naturally.
    always_comb begin
        w_pcNext = r_pc + PC_W'(1);
        if ((w_irCls == CLS_BR) && condTaken(w_irRd, r_z, r_n)) begin
            w_pcNext = PC_W'(w_irImm);
        end
    end

    // Sequencer. All outputs are registered, so each is set on the edge
    // that enters the state where it must be visible: imem_en on entry to
    // FETCH, ALU operands on entry to EXEC, retire on entry to the
    // completing state (EXEC for single-step classes, WB for ALU).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_ir     <= 12'd0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_imemEn <= 1'b0;
            r_aluOp  <= 4'd0;
            r_aluRx  <= 4'd0;
            r_aluRy  <= 4'd0;
            r_halted <= 1'b0;
            r_retire <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state  <= ST_FETCH;
                        r_imemEn <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_imemEn <= 1'b0;
                    r_state  <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= ST_EXEC;
                    if (w_dataCls == CLS_ALU) begin
                        r_aluOp <= w_dataImm;
                        r_aluRx <= w_rdataA;
                        r_aluRy <= w_rdataB;
                    end else begin
                        r_retire <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_irCls == CLS_ALU) begin
                        r_aluOp  <= 4'd0;
                        r_aluRx  <= 4'd0;
                        r_aluRy  <= 4'd0;
                        r_retire <= 1'b1;
                        r_state  <= ST_WB;
                    end else if ((w_irCls == CLS_SYS) && (w_irImm == IMM_HALT)) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_pc     <= w_pcNext;
                        r_imemEn <= run;
                        r_state  <= run ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_WB: begin
                    r_z      <= alu_z;
                    r_n      <= alu_n;
                    r_pc     <= w_pcNext;
                    r_imemEn <= run;
                    r_state  <= run ? ST_FETCH : ST_IDLE;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign imem_en   = r_imemEn;
    assign alu_op    = r_aluOp;
    assign alu_rx    = r_aluRx;
    assign alu_ry    = r_aluRy;
    assign halted    = r_halted;
    assign retire    = r_retire;
    assign pc        = r_pc;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl
// Self-checking bench for cpu_ctrl. Provides a 16-word synchronous ROM
// and a registered-adder ALU stub (out = rx + ry mod 16, z = out==0,
// n = out[3]). Programs are described as tables of executed instructions
// with hand-computed post-conditions; multi-cycle corners are scripted.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] instr;
        int          lat;
        logic [3:0]  op;
        logic [3:0]  rx;
        logic [3:0]  ry;
        logic [1:0]  sel;
        logic [3:0]  val;
        logic        z;
        logic        n;
        logic [3:0]  pcAfter;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic [3:0]  imem_addr;
    logic        imem_en;
    logic [11:0] imem_data;
    logic [3:0]  alu_op;
    logic [3:0]  alu_rx;
    logic [3:0]  alu_ry;
    logic [3:0]  aluOut;
    logic        aluZ;
    logic        aluN;
    logic        halted;
    logic        retire;
    logic [3:0]  pc;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;

    logic [11:0] rom [16];
    logic [3:0]  stubSum;
    vec_t        vecs [14];
    int          total;
    int          bad;
    int          retiresSeen;

    cpu_ctrl #(.PC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .imem_data (imem_data),
        .alu_op    (alu_op),
        .alu_rx    (alu_rx),
        .alu_ry    (alu_ry),
        .alu_out   (aluOut),
        .alu_z     (aluZ),
        .alu_n     (aluN),
        .halted    (halted),
        .retire    (retire),
        .pc        (pc),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous program ROM: data appears the cycle after imem_en.
    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
    end

    // Registered adder standing in for the ALU.
    assign stubSum = alu_rx + alu_ry;
    always @(posedge clk) begin
        aluOut <= stubSum;
        aluZ   <= (stubSum == 4'd0);
        aluN   <= stubSum[3];
    end

    function automatic vec_t mkVec(input logic [3:0] a, input logic [11:0] ins, input int l,
                                   input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                                   input logic [1:0] s, input logic [3:0] v,
                                   input logic z, input logic n, input logic [3:0] p);
        vec_t r;
        r.addr = a; r.instr = ins; r.lat = l; r.op = op; r.rx = rx; r.ry = ry;
        r.sel = s; r.val = v; r.z = z; r.n = n; r.pcAfter = p;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic runV);
        rst = rstV;
        run = runV;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic loadRom(input logic [11:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    task automatic waitFetch();
        int k;
        k = 0;
        while (!imem_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!imem_en) checkOutput("fetch_timeout", 16'd0, 16'd1);
    endtask

    // Counts negedges from the FETCH cycle (=1) to the retire pulse.
    task automatic waitRetire(input int startCyc, output int cyc);
        cyc = startCyc;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (retire) break;
        end
        if (!retire) cyc = 99;
    endtask

    task automatic runTable(input int lo, input int hi);
        int cyc;
        logic got;
        logic [3:0] sOp, sRx, sRy, sRxWb;
        loadRom(12'hC40);
        for (int i = lo; i <= hi; i++) rom[vecs[i].addr] = vecs[i].instr;
        doReset();
        applyStimulus(1'b0, 1'b1);
        retiresSeen = 0;
        for (int i = lo; i <= hi; i++) begin
            waitFetch();
            checkOutput("fetch_addr", 16'(imem_addr), 16'(vecs[i].addr));
            cyc = 1; got = 1'b0;
            sOp = 4'd0; sRx = 4'd0; sRy = 4'd0; sRxWb = 4'd0;
            while (!got && cyc < 10) begin
                @(negedge clk);
                cyc++;
                if (cyc == 3) begin
                    sOp = alu_op; sRx = alu_rx; sRy = alu_ry;
                end
                if (cyc == 4) sRxWb = alu_rx;
                if (retire) got = 1'b1;
            end
            checkOutput("retire_latency", 16'(got ? cyc : 99), 16'(vecs[i].lat));
            if (got) retiresSeen++;
            checkOutput("exec_alu_op", 16'(sOp), 16'(vecs[i].op));
            checkOutput("exec_alu_rx", 16'(sRx), 16'(vecs[i].rx));
            checkOutput("exec_alu_ry", 16'(sRy), 16'(vecs[i].ry));
            checkOutput("wb_alu_rx_zero", 16'(sRxWb), 16'd0);
            @(negedge clk);
            dbg_sel = vecs[i].sel;
            #1;
            checkOutput("reg_value", 16'(dbg_data), 16'(vecs[i].val));
            checkOutput("pc_after", 16'(pc), 16'(vecs[i].pcAfter));
            checkOutput("flag_z", 16'(dut.r_z), 16'(vecs[i].z));
            checkOutput("flag_n", 16'(dut.r_n), 16'(vecs[i].n));
        end
    endtask

    initial begin
        int cyc;
        total = 0;
        bad = 0;
        dbg_sel = 2'd0;
        applyStimulus(1'b1, 1'b0);

        // Program 1: LDI R0,5; LDI R1,1; ALU op0 R0,R1; HALT
        vecs[0]  = mkVec(4'd0,  12'h540, 3, 4'h0, 4'h0, 4'h0, 2'd0, 4'd5,  1'b0, 1'b0, 4'd1);
        vecs[1]  = mkVec(4'd1,  12'h450, 3, 4'h0, 4'h0, 4'h0, 2'd1, 4'd1,  1'b0, 1'b0, 4'd2);
        vecs[2]  = mkVec(4'd2,  12'h004, 4, 4'h0, 4'h5, 4'h1, 2'd0, 4'd6,  1'b0, 1'b0, 4'd3);
        vecs[3]  = mkVec(4'd3,  12'hC00, 3, 4'h0, 4'h0, 4'h0, 2'd0, 4'd6,  1'b0, 1'b0, 4'd3);
        // Program 2: flags, branches, rd==rs, pc wrap
        vecs[4]  = mkVec(4'd0,  12'h7E0, 3, 4'h0, 4'h0, 4'h0, 2'd2, 4'd15, 1'b0, 1'b0, 4'd1);
        vecs[5]  = mkVec(4'd1,  12'h470, 3, 4'h0, 4'h0, 4'h0, 2'd3, 4'd1,  1'b0, 1'b0, 4'd2);
        vecs[6]  = mkVec(4'd2,  12'h02C, 4, 4'h0, 4'hF, 4'h1, 2'd2, 4'd0,  1'b1, 1'b0, 4'd3);
        vecs[7]  = mkVec(4'd3,  12'hA50, 3, 4'h0, 4'h0, 4'h0, 2'd2, 4'd0,  1'b1, 1'b0, 4'd9);
        vecs[8]  = mkVec(4'd9,  12'h8B0, 3, 4'h0, 4'h0, 4'h0, 2'd2, 4'd0,  1'b1, 1'b0, 4'd10);
        vecs[9]  = mkVec(4'd10, 12'h5D0, 3, 4'h0, 4'h0, 4'h0, 2'd1, 4'd7,  1'b1, 1'b0, 4'd11);
        vecs[10] = mkVec(4'd11, 12'h014, 4, 4'h0, 4'h7, 4'h7, 2'd1, 4'd14, 1'b0, 1'b1, 4'd12);
        vecs[11] = mkVec(4'd12, 12'hBA0, 3, 4'h0, 4'h0, 4'h0, 2'd1, 4'd14, 1'b0, 1'b1, 4'd14);
        vecs[12] = mkVec(4'd14, 12'hBC0, 3, 4'h0, 4'h0, 4'h0, 2'd1, 4'd14, 1'b0, 1'b1, 4'd15);
        vecs[13] = mkVec(4'd15, 12'h4C0, 3, 4'h0, 4'h0, 4'h0, 2'd0, 4'd3,  1'b0, 1'b1, 4'd0);

        // Reset state
        loadRom(12'hC40);
        doReset();
        #1;
        checkOutput("rst_pc", 16'(pc), 16'd0);
        checkOutput("rst_imem_en", 16'(imem_en), 16'd0);
        checkOutput("rst_imem_addr", 16'(imem_addr), 16'd0);
        checkOutput("rst_halted", 16'(halted), 16'd0);
        checkOutput("rst_retire", 16'(retire), 16'd0);
        checkOutput("rst_alu", 16'({alu_op, alu_rx, alu_ry}), 16'd0);
        checkOutput("rst_state", 16'(dut.r_state), 16'(ST_IDLE));
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            checkOutput("rst_reg", 16'(dbg_data), 16'd0);
        end

        // Program 1 then HALT behaviour
        runTable(0, 3);
        checkOutput("halted_high", 16'(halted), 16'd1);
        repeat (10) begin
            @(negedge clk);
            if (retire) retiresSeen++;
        end
        checkOutput("retire_count", 16'(retiresSeen), 16'd4);
        checkOutput("halt_pc", 16'(pc), 16'd3);
        checkOutput("halt_imem_en", 16'(imem_en), 16'd0);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("halt_reset_halted", 16'(halted), 16'd0);
        checkOutput("halt_reset_state", 16'(dut.r_state), 16'(ST_IDLE));

        // Program 2
        runTable(4, 13);

        // pc wrap over 16 NOPs
        loadRom(12'hC40);
        doReset();
        applyStimulus(1'b0, 1'b1);
        waitFetch();
        cyc = 1;
        for (int k = 0; k < 16; k++) begin
            waitRetire(cyc, cyc);
            checkOutput("nop_interval", 16'(cyc), 16'd3);
            cyc = 0;
        end
        @(negedge clk);
        checkOutput("wrap_pc", 16'(pc), 16'd0);

        // Drop run during DECODE of an ALU instruction
        loadRom(12'hC40);
        rom[0] = 12'h540;
        rom[1] = 12'h000;
        rom[2] = 12'h450;
        doReset();
        applyStimulus(1'b0, 1'b1);
        waitFetch();
        waitRetire(1, cyc);
        @(negedge clk);
        checkOutput("drop_fetch", 16'(imem_en), 16'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        waitRetire(2, cyc);
        checkOutput("drop_alu_latency", 16'(cyc), 16'd4);
        @(negedge clk);
        dbg_sel = 2'd0;
        #1;
        checkOutput("drop_imem_en", 16'(imem_en), 16'd0);
        checkOutput("drop_state", 16'(dut.r_state), 16'(ST_IDLE));
        checkOutput("drop_r0", 16'(dbg_data), 16'd10);
        checkOutput("drop_pc", 16'(pc), 16'd2);
        repeat (3) @(negedge clk);
        checkOutput("drop_still_idle", 16'(imem_en), 16'd0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("resume_imem_en", 16'(imem_en), 16'd1);
        checkOutput("resume_addr", 16'(imem_addr), 16'd2);

        // Reset during WB of an ALU instruction
        doReset();
        applyStimulus(1'b0, 1'b1);
        waitFetch();
        waitRetire(1, cyc);
        repeat (4) @(negedge clk);
        checkOutput("wb_retire", 16'(retire), 16'd1);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        dbg_sel = 2'd0;
        #1;
        checkOutput("wbrst_state", 16'(dut.r_state), 16'(ST_IDLE));
        checkOutput("wbrst_retire", 16'(retire), 16'd0);
        checkOutput("wbrst_pc", 16'(pc), 16'd0);
        checkOutput("wbrst_r0", 16'(dbg_data), 16'd0);
        checkOutput("wbrst_flags", 16'({dut.r_z, dut.r_n}), 16'd0);
        checkOutput("wbrst_imem_en", 16'(imem_en), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
